// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the HD44780 instruction sequencer.
// Holds the power-on init ROM and the instruction field positions.
package lcd_seq_pkg;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PWR_WAIT   = 3'd1,
      INIT_ISSUE = 3'd2,
      INIT_GAP   = 3'd3,
      RUN        = 3'd4
   } seq_state_e;

   localparam int INIT_LEN   = 4;
   localparam int INIT_IDX_W = 2;
   localparam int ROM_WIDTH  = 10;

   // Instruction layout {RS, RW, DB[7:0]}
   localparam int RS_BIT = 9;
   localparam int RW_BIT = 8;

   // function set, display on, clear, entry mode
   localparam logic [ROM_WIDTH-1:0] INIT_ROM [INIT_LEN] = '{
      10'h038, 10'h00C, 10'h001, 10'h006
   };

endpackage

// File: rtl/lcd_instr_fifo.sv
// Host instruction FIFO; push visible in level next cycle, head readable combinationally.
// Push while full is ignored unless a pop happens in the same cycle; flush empties it.
module lcd_instr_fifo #(
   parameter int INSTR_WIDTH = 10,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          i_push,
   input  logic [INSTR_WIDTH-1:0]        i_push_dat,
   input  logic                          i_pop,
   output logic [INSTR_WIDTH-1:0]        o_pop_dat,
   input  logic                          i_flush,
   output logic                          o_full,
   output logic                          o_empty,
   output logic [$clog2(FIFO_DEPTH):0]   o_level
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   logic [INSTR_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]          r_wr_ptr;
   logic [AW-1:0]          r_rd_ptr;
   logic [LW-1:0]          r_level;
   logic                   w_wr;
   logic                   w_rd;

   assign o_full    = (r_level == LW'(FIFO_DEPTH));
   assign o_empty   = (r_level == '0);
   assign o_level   = r_level;
   assign o_pop_dat = r_mem[r_rd_ptr];

   assign w_rd = i_pop && !o_empty;
   assign w_wr = i_push && (!o_full || w_rd);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_level <= r_level + LW'(w_wr) - LW'(w_rd);
      end
   end

   always_ff @(posedge clk_i) begin
      if (w_wr && !i_flush) r_mem[r_wr_ptr] <= i_push_dat;
   end

endmodule

// File: rtl/lcd_instr_sequencer.sv
// Runs the HD44780 init ROM after enable, then drains host instructions to the PHY.
// Outputs registered; one instruction per cycle while phy_ready_i=1, held stable otherwise.
module lcd_instr_sequencer
   import lcd_seq_pkg::*;
#(
   parameter int INSTR_WIDTH     = 10,
   parameter int PRESCALER_WIDTH = 16,
   parameter int FIFO_DEPTH      = 4,
   parameter int POWERUP_TICKS   = 4000,
   parameter int CMD_GAP_TICKS   = 200
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         enable_i,
   input  logic [PRESCALER_WIDTH-1:0]   prescaler_i,
   input  logic [INSTR_WIDTH-1:0]       host_instr_i,
   input  logic                         host_valid_i,
   output logic [INSTR_WIDTH-1:0]       phy_instr_o,
   output logic                         phy_valid_o,
   input  logic                         phy_ready_i,
   output logic                         init_done_o,
   output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
   output logic                         overflow_o,
   input  logic                         overflow_clr_i
);

   localparam int PW        = PRESCALER_WIDTH;
   localparam int MAX_TICKS = (POWERUP_TICKS > CMD_GAP_TICKS) ? POWERUP_TICKS : CMD_GAP_TICKS;
   localparam int TW        = $clog2(MAX_TICKS + 1);

   seq_state_e              r_state, w_state_nxt;
   logic [INIT_IDX_W-1:0]   r_idx, w_idx_nxt;
   logic [PW-1:0]           r_tick_cnt;
   logic [TW-1:0]           r_tick_num;
   logic [PW-1:0]           w_presc_eff;
   logic                    w_tick_run, w_tick, w_xfer;
   logic                    w_pwr_done, w_gap_done;

   logic                    r_phy_valid, w_phy_valid_nxt;
   logic [INSTR_WIDTH-1:0]  r_phy_instr, w_phy_instr_nxt;
   logic                    r_init_done, w_init_done_nxt;
   logic                    r_overflow;

   logic                    w_push_req, w_push, w_pop, w_flush, w_ovf_set;
   logic                    w_full, w_empty;
   logic [INSTR_WIDTH-1:0]  w_head;
   logic [$clog2(FIFO_DEPTH):0] w_level;

   assign w_presc_eff = (prescaler_i == '0) ? PW'(1) : prescaler_i;
   assign w_tick_run  = (r_state == PWR_WAIT) || (r_state == INIT_GAP);
   // >= so that lowering the prescaler below the running count still wraps
   assign w_tick      = w_tick_run && (r_tick_cnt >= w_presc_eff - PW'(1));
   assign w_pwr_done  = w_tick && (r_tick_num == TW'(POWERUP_TICKS - 1));
   assign w_gap_done  = w_tick && (r_tick_num == TW'(CMD_GAP_TICKS - 1));
   assign w_xfer      = r_phy_valid && phy_ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_tick_cnt <= '0;
         r_tick_num <= '0;
      end else if (!w_tick_run) begin
         r_tick_cnt <= '0;
         r_tick_num <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
         r_tick_num <= r_tick_num + TW'(1);
      end else begin
         r_tick_cnt <= r_tick_cnt + PW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      if (!enable_i) begin
         w_state_nxt = IDLE;
      end else begin
         case (r_state)
            IDLE:       w_state_nxt = PWR_WAIT;
            PWR_WAIT: begin
               if (w_pwr_done) begin
                  w_state_nxt = INIT_ISSUE;
                  w_idx_nxt   = '0;
               end
            end
            INIT_ISSUE: if (w_xfer) w_state_nxt = INIT_GAP;
            INIT_GAP: begin
               if (w_gap_done) begin
                  if (r_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
                     w_state_nxt = RUN;
                  end else begin
                     w_state_nxt = INIT_ISSUE;
                     w_idx_nxt   = r_idx + INIT_IDX_W'(1);
                  end
               end
            end
            RUN:        w_state_nxt = RUN;
            default:    w_state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      w_phy_valid_nxt = r_phy_valid;
      w_phy_instr_nxt = r_phy_instr;
      w_init_done_nxt = r_init_done;
      w_pop           = 1'b0;
      if (!enable_i) begin
         w_phy_valid_nxt = 1'b0;
         w_init_done_nxt = 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               w_phy_valid_nxt = 1'b0;
               w_init_done_nxt = 1'b0;
            end
            PWR_WAIT: begin
               if (w_pwr_done) begin
                  w_phy_valid_nxt = 1'b1;
                  w_phy_instr_nxt = INSTR_WIDTH'(INIT_ROM[0]);
               end
            end
            INIT_ISSUE: if (w_xfer) w_phy_valid_nxt = 1'b0;
            INIT_GAP: begin
               if (w_gap_done) begin
                  if (r_idx == INIT_IDX_W'(INIT_LEN - 1)) begin
                     w_init_done_nxt = 1'b1;
                  end else begin
                     w_phy_valid_nxt = 1'b1;
                     w_phy_instr_nxt = INSTR_WIDTH'(INIT_ROM[w_idx_nxt]);
                  end
               end
            end
            RUN: begin
               if (!w_empty && (!r_phy_valid || w_xfer)) begin
                  w_pop           = 1'b1;
                  w_phy_valid_nxt = 1'b1;
                  w_phy_instr_nxt = w_head;
               end else if (w_xfer) begin
                  w_phy_valid_nxt = 1'b0;
               end
            end
            default: begin
               w_phy_valid_nxt = 1'b0;
               w_init_done_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_phy_valid <= 1'b0;
         r_phy_instr <= '0;
         r_init_done <= 1'b0;
      end else begin
         r_phy_valid <= w_phy_valid_nxt;
         r_phy_instr <= w_phy_instr_nxt;
         r_init_done <= w_init_done_nxt;
      end
   end

   // Pushes in IDLE (or while disabling) vanish silently and never flag overflow
   assign w_push_req = host_valid_i && enable_i && (r_state != IDLE);
   assign w_push     = w_push_req && (!w_full || w_pop);
   assign w_ovf_set  = w_push_req && w_full && !w_pop;
   assign w_flush    = !enable_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)             r_overflow <= 1'b0;
      else if (w_ovf_set)      r_overflow <= 1'b1;
      else if (overflow_clr_i) r_overflow <= 1'b0;
   end

   lcd_instr_fifo #(
      .INSTR_WIDTH (INSTR_WIDTH),
      .FIFO_DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .i_push     (w_push),
      .i_push_dat (host_instr_i),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .i_flush    (w_flush),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_level    (w_level)
   );

   assign phy_instr_o  = r_phy_instr;
   assign phy_valid_o  = r_phy_valid;
   assign init_done_o  = r_init_done;
   assign fifo_level_o = w_level;
   assign overflow_o   = r_overflow;

endmodule
